// File: rtl/decim_capture_ctrl.sv
// rtl/decim_capture_ctrl.sv - decimates ADC samples into N-beat AXIS capture frames
// Optional level trigger (ARM state, trig_level port) enabled by DECIM_TRIGGER_LEVEL_EN.
module decim_capture_ctrl #(
  parameter int DATA_WIDTH  = 12,
  parameter int RATIO_WIDTH = 8,
  parameter int LEN_WIDTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic signed [DATA_WIDTH-1:0]  data_in,
`ifdef DECIM_TRIGGER_LEVEL_EN
  input  logic signed [DATA_WIDTH-1:0]  trig_level,
`endif
  input  logic        [RATIO_WIDTH-1:0] cfg_ratio,
  input  logic        [LEN_WIDTH-1:0]   cfg_frame_len,
  input  logic                          start,
  input  logic                          abort,
  output logic signed [DATA_WIDTH-1:0]  m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
`ifdef DECIM_TRIGGER_LEVEL_EN
    S_ARM     = 2'd1,
`endif
    S_CAPTURE = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;

  state_t                 state;
  logic [RATIO_WIDTH-1:0] ratio_q;
  logic [LEN_WIDTH-1:0]   len_q;
  logic [RATIO_WIDTH-1:0] phase;
  logic [LEN_WIDTH-1:0]   beat_cnt;

`ifdef DECIM_TRIGGER_LEVEL_EN
  logic signed [DATA_WIDTH-1:0] prev_sample;
  logic                         seeded;
  logic                         trig_hit;
`endif

  logic                   strobe;
  logic                   slot_free;
  logic [LEN_WIDTH-1:0]   beat_next;
  logic                   last_next;
  logic [RATIO_WIDTH-1:0] phase_next;

  assign strobe     = (phase == ratio_q - RATIO_WIDTH'(1));
  assign phase_next = strobe ? '0 : phase + RATIO_WIDTH'(1);
  // The output register can take a new beat if empty or emptying this cycle.
  assign slot_free  = !m_axis_tvalid || m_axis_tready;
  assign beat_next  = beat_cnt + LEN_WIDTH'(1);
  assign last_next  = (beat_next == len_q);
  assign busy       = (state != S_IDLE);

`ifdef DECIM_TRIGGER_LEVEL_EN
  assign trig_hit = seeded && (prev_sample < trig_level) && (data_in >= trig_level);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      ratio_q       <= RATIO_WIDTH'(1);
      len_q         <= LEN_WIDTH'(1);
      phase         <= '0;
      beat_cnt      <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      done          <= 1'b0;
      overflow      <= 1'b0;
`ifdef DECIM_TRIGGER_LEVEL_EN
      prev_sample   <= '0;
      seeded        <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          m_axis_tvalid <= 1'b0;
          m_axis_tlast  <= 1'b0;
          if (start && !abort) begin
            ratio_q  <= (cfg_ratio == '0) ? RATIO_WIDTH'(1) : cfg_ratio;
            len_q    <= (cfg_frame_len == '0) ? LEN_WIDTH'(1) : cfg_frame_len;
            phase    <= '0;
            beat_cnt <= '0;
            overflow <= 1'b0;
`ifdef DECIM_TRIGGER_LEVEL_EN
            seeded   <= 1'b0;
            state    <= S_ARM;
`else
            state    <= S_CAPTURE;
`endif
          end
        end

`ifdef DECIM_TRIGGER_LEVEL_EN
        // The crossing sample itself becomes beat 1 of the frame.
        S_ARM: begin
          phase <= phase_next;
          if (abort) begin
            state <= S_IDLE;
          end else if (strobe) begin
            prev_sample <= data_in;
            seeded      <= 1'b1;
            if (trig_hit) begin
              phase         <= '0;
              m_axis_tdata  <= data_in;
              m_axis_tvalid <= 1'b1;
              beat_cnt      <= beat_next;
              m_axis_tlast  <= last_next;
              state         <= last_next ? S_DRAIN : S_CAPTURE;
            end
          end
        end
`endif

        S_CAPTURE: begin
          phase <= phase_next;
          if (abort) begin
            if (m_axis_tvalid && !m_axis_tready) begin
              m_axis_tlast <= 1'b1;
              state        <= S_DRAIN;
            end else begin
              m_axis_tvalid <= 1'b0;
              m_axis_tlast  <= 1'b0;
              state         <= S_IDLE;
            end
          end else begin
            if (m_axis_tvalid && m_axis_tready) begin
              m_axis_tvalid <= 1'b0;
              m_axis_tlast  <= 1'b0;
            end
            if (strobe) begin
              if (slot_free) begin
                m_axis_tdata  <= data_in;
                m_axis_tvalid <= 1'b1;
                beat_cnt      <= beat_next;
                m_axis_tlast  <= last_next;
                if (last_next) state <= S_DRAIN;
              end else begin
                overflow <= 1'b1;
              end
            end
          end
        end

        S_DRAIN: begin
          if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            done          <= 1'b1;
            state         <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
